// File: rtl/match_controller.sv
// Round/match sequencer for the two-player fighter, clocked once per video frame.
// Walks IDLE -> INTRO -> FIGHT -> KO -> (INTRO | MATCH_OVER). It owns the round timer,
// the win tally and the last-round result. It gates player logic via fight_enable and
// re-arms both health bars with a one-frame health_reset pulse before every round.
//
// Ports:
//   Clk, Reset_n               frame clock, synchronous active-low reset
//   start                      start button level (edge-detected internally)
//   ryu_health, akuma_health   health bar values, 0 = knocked out
//   state                      0 IDLE, 1 INTRO, 2 FIGHT, 3 KO, 4 MATCH_OVER
//   fight_enable, match_over   decoded from state
//   health_reset               registered pulse during the first INTRO frame
//   round_num, ryu_wins, akuma_wins, timer_sec, round_winner   registered status
module match_controller #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned ROUND_TIME_SEC = 99,
  parameter int unsigned INTRO_FRAMES   = 120,
  parameter int unsigned KO_FRAMES      = 180,
  parameter int unsigned ROUNDS_TO_WIN  = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic [7:0] ryu_health,
  input  logic [7:0] akuma_health,
  output logic [2:0] state,
  output logic       fight_enable,
  output logic       health_reset,
  output logic [1:0] round_num,
  output logic [1:0] ryu_wins,
  output logic [1:0] akuma_wins,
  output logic [6:0] timer_sec,
  output logic [1:0] round_winner,
  output logic       match_over
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StIntro     = 3'd1,
    StFight     = 3'd2,
    StKo        = 3'd3,
    StMatchOver = 3'd4
  } state_e;

  // One shared frame counter serves every timed phase; size it for the longest one.
  localparam int unsigned MaxAb  = (FRAMES_PER_SEC > INTRO_FRAMES) ? FRAMES_PER_SEC
                                                                   : INTRO_FRAMES;
  localparam int unsigned CntMax = (MaxAb > KO_FRAMES) ? MaxAb : KO_FRAMES;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] IntroLast = CntW'(INTRO_FRAMES - 1);
  localparam logic [CntW-1:0] KoLast    = CntW'(KO_FRAMES - 1);
  localparam logic [CntW-1:0] SecLast   = CntW'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]      RoundTime = 7'(ROUND_TIME_SEC);
  localparam logic [1:0]      WinsMax   = 2'(ROUNDS_TO_WIN);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_q, start_d;
  logic            health_reset_q, health_reset_d;
  logic [1:0]      round_num_q, round_num_d;
  logic [1:0]      ryu_wins_q, ryu_wins_d;
  logic [1:0]      akuma_wins_q, akuma_wins_d;
  logic [6:0]      timer_q, timer_d;
  logic [1:0]      round_winner_q, round_winner_d;

  logic            start_pulse;
  logic [1:0]      result;  // 00 no end, 01 Ryu, 10 Akuma, 11 draw

  assign start_pulse = start & ~start_q;

  // Round-end evaluation; KO beats time-out, so a KO on the zero-timer frame is a KO.
  always_comb begin
    result = 2'b00;
    if (ryu_health == 8'd0 && akuma_health == 8'd0) begin
      result = 2'b11;
    end else if (ryu_health == 8'd0) begin
      result = 2'b10;
    end else if (akuma_health == 8'd0) begin
      result = 2'b01;
    end else if (timer_q == 7'd0) begin
      if (ryu_health > akuma_health) begin
        result = 2'b01;
      end else if (ryu_health < akuma_health) begin
        result = 2'b10;
      end else begin
        result = 2'b11;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    start_d        = start;
    health_reset_d = 1'b0;
    round_num_d    = round_num_q;
    ryu_wins_d     = ryu_wins_q;
    akuma_wins_d   = akuma_wins_q;
    timer_d        = timer_q;
    round_winner_d = round_winner_q;

    case (state_q)
      StIdle, StMatchOver: begin
        if (start_pulse) begin
          state_d        = StIntro;
          cnt_d          = '0;
          health_reset_d = 1'b1;
          round_num_d    = 2'd1;
          ryu_wins_d     = 2'd0;
          akuma_wins_d   = 2'd0;
          timer_d        = RoundTime;
          round_winner_d = 2'b00;
        end
      end

      StIntro: begin
        if (cnt_q == IntroLast) begin
          state_d = StFight;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StFight: begin
        if (result != 2'b00) begin
          state_d        = StKo;
          cnt_d          = '0;
          round_winner_d = result;
          // A draw credits both sides.
          if (result[0] && ryu_wins_q < WinsMax) ryu_wins_d = ryu_wins_q + 2'd1;
          if (result[1] && akuma_wins_q < WinsMax) akuma_wins_d = akuma_wins_q + 2'd1;
        end else if (cnt_q == SecLast) begin
          cnt_d = '0;
          if (timer_q != 7'd0) timer_d = timer_q - 7'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StKo: begin
        if (cnt_q == KoLast) begin
          cnt_d = '0;
          if (ryu_wins_q == WinsMax || akuma_wins_q == WinsMax) begin
            state_d = StMatchOver;
          end else begin
            state_d        = StIntro;
            health_reset_d = 1'b1;
            timer_d        = RoundTime;
            if (round_num_q != 2'd3) round_num_d = round_num_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      start_q        <= 1'b0;
      health_reset_q <= 1'b0;
      round_num_q    <= 2'd0;
      ryu_wins_q     <= 2'd0;
      akuma_wins_q   <= 2'd0;
      timer_q        <= 7'd0;
      round_winner_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      start_q        <= start_d;
      health_reset_q <= health_reset_d;
      round_num_q    <= round_num_d;
      ryu_wins_q     <= ryu_wins_d;
      akuma_wins_q   <= akuma_wins_d;
      timer_q        <= timer_d;
      round_winner_q <= round_winner_d;
    end
  end

  assign state        = state_q;
  assign fight_enable = (state_q == StFight);
  assign match_over   = (state_q == StMatchOver);
  assign health_reset = health_reset_q;
  assign round_num    = round_num_q;
  assign ryu_wins     = ryu_wins_q;
  assign akuma_wins   = akuma_wins_q;
  assign timer_sec    = timer_q;
  assign round_winner = round_winner_q;

endmodule
